sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO, the next generation of the team's fixed-geometry sync FIFO. It adds independent width and depth parameters with non-power-of-two depth support, programmable almost-full/almost-empty thresholds, and an occupancy count output. It also offers a selectable first-word-fall-through (FWFT) read mode. It is a drop-in single-clock buffer for datapath blocks and keeps the existing handshake and status flag set.

---
 rtl/sync_fifo_param_if.sv | 31 +++
 rtl/sync_fifo_param.sv | 94 +++++++++
 tb/tb_sync_fifo_param.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// The master side drives requests and write data; the slave side is the FIFO.
interface sync_fifo_param_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
);
    logic                              wr_en;
    logic                              rd_en;
    logic [FIFO_WIDTH-1:0]             data_in;
    logic [FIFO_WIDTH-1:0]             data_out;
    logic                              wr_ack;
    logic                              overflow;
    logic                              underflow;
    logic                              full;
    logic                              empty;
    logic                              almostfull;
    logic                              almostempty;
    logic [$clog2(FIFO_DEPTH+1)-1:0]   count;

    modport master (
        output wr_en, rd_en, data_in,
        input  data_out, wr_ack, overflow, underflow,
        input  full, empty, almostfull, almostempty, count
    );

    modport slave (
        input  wr_en, rd_en, data_in,
        output data_out, wr_ack, overflow, underflow,
        output full, empty, almostfull, almostempty, count
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with arbitrary depth, programmable almost flags,
// occupancy count and selectable standard or first-word-fall-through reads.
module sync_fifo_param #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_MARGIN  = 1,
    parameter int AE_MARGIN  = 1,
    parameter int FWFT       = 0
) (
    input  logic              clk,
    input  logic              rst,
    sync_fifo_param_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(FIFO_DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_MARGIN);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wp;
    logic [PW-1:0]         rp;
    logic [CW-1:0]         count_r;
    logic [FIFO_WIDTH-1:0] dout;
    logic                  wr_ack_r;
    logic                  overflow_r;
    logic                  underflow_r;
    logic                  is_full;
    logic                  is_empty;
    logic                  wr_accept;
    logic                  rd_accept;

    // Depth need not be a power of two, so wrap is an explicit compare.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // A read frees a slot in the same cycle, so a full FIFO still takes a write.
    always_comb begin
        is_full   = (count_r == CNT_FULL);
        is_empty  = (count_r == '0);
        rd_accept = bus.rd_en && !is_empty;
        wr_accept = bus.wr_en && (!is_full || rd_accept);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp          <= '0;
            rp          <= '0;
            count_r     <= '0;
            wr_ack_r    <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_accept) wp <= ptr_next(wp);
            if (rd_accept) rp <= ptr_next(rp);
            case ({wr_accept, rd_accept})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            wr_ack_r    <= wr_accept;
            overflow_r  <= bus.wr_en && !wr_accept;
            underflow_r <= bus.rd_en && !rd_accept;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept && !rst) mem[wp] <= bus.data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout = mem[rp];
        end else begin : g_std
            always_ff @(posedge clk) begin
                if (rst)            dout <= '0;
                else if (rd_accept) dout <= mem[rp];
            end
        end
    endgenerate

    assign bus.data_out    = dout;
    assign bus.wr_ack      = wr_ack_r;
    assign bus.overflow    = overflow_r;
    assign bus.underflow   = underflow_r;
    assign bus.full        = is_full;
    assign bus.empty       = is_empty;
    assign bus.almostfull  = (count_r >= CNT_AF) && !is_full;
    assign bus.almostempty = !is_empty && (count_r <= CNT_AE);
    assign bus.count       = count_r;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a depth-8 standard-read FIFO and a depth-5 FWFT FIFO,
// each checked every cycle against a queue model, plus directed literal checks.
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) b8 ();
    sync_fifo_param_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) b5 ();

    sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_MARGIN(2), .AE_MARGIN(2), .FWFT(0))
        u8 (.clk(clk), .rst(rst), .bus(b8.slave));
    sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_MARGIN(2), .AE_MARGIN(1), .FWFT(1))
        u5 (.clk(clk), .rst(rst), .bus(b5.slave));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Depth-8, standard read, AF=2, AE=2 model
    logic [15:0] q8[$];
    logic [15:0] dout8;
    logic        ack8, ovf8, udf8, ra8, wa8;
    bit          on8 = 0;

    always @(posedge clk) begin
        if (rst) begin
            q8.delete();
            dout8 = '0; ack8 = 0; ovf8 = 0; udf8 = 0; on8 = 1;
        end else begin
            ra8 = b8.rd_en && (q8.size() != 0);
            wa8 = b8.wr_en && (q8.size() < 8 || ra8);
            if (ra8) dout8 = q8.pop_front();
            if (wa8) q8.push_back(b8.data_in);
            ack8 = wa8;
            ovf8 = b8.wr_en && !wa8;
            udf8 = b8.rd_en && !ra8;
        end
        #1;
        if (on8) begin
            chk("u8 count", b8.count, q8.size());
            chk("u8 full", b8.full, q8.size() == 8);
            chk("u8 empty", b8.empty, q8.size() == 0);
            chk("u8 almostfull", b8.almostfull, q8.size() >= 6 && q8.size() < 8);
            chk("u8 almostempty", b8.almostempty, q8.size() > 0 && q8.size() <= 2);
            chk("u8 wr_ack", b8.wr_ack, ack8);
            chk("u8 overflow", b8.overflow, ovf8);
            chk("u8 underflow", b8.underflow, udf8);
            chk("u8 data_out", b8.data_out, dout8);
        end
    end

    // Depth-5, FWFT, AF=2, AE=1 model; head is compared once it has sat one edge
    logic [15:0] q5[$];
    logic        ack5, ovf5, udf5, ra5, wa5, fresh5;
    bit          on5 = 0;

    always @(posedge clk) begin
        if (rst) begin
            q5.delete();
            ack5 = 0; ovf5 = 0; udf5 = 0; fresh5 = 0; on5 = 1;
        end else begin
            fresh5 = 0;
            ra5 = b5.rd_en && (q5.size() != 0);
            wa5 = b5.wr_en && (q5.size() < 5 || ra5);
            if (ra5) void'(q5.pop_front());
            if (wa5) begin
                fresh5 = (q5.size() == 0);
                q5.push_back(b5.data_in);
            end
            ack5 = wa5;
            ovf5 = b5.wr_en && !wa5;
            udf5 = b5.rd_en && !ra5;
        end
        #1;
        if (on5) begin
            chk("u5 count", b5.count, q5.size());
            chk("u5 full", b5.full, q5.size() == 5);
            chk("u5 empty", b5.empty, q5.size() == 0);
            chk("u5 almostfull", b5.almostfull, q5.size() >= 3 && q5.size() < 5);
            chk("u5 almostempty", b5.almostempty, q5.size() == 1);
            chk("u5 wr_ack", b5.wr_ack, ack5);
            chk("u5 overflow", b5.overflow, ovf5);
            chk("u5 underflow", b5.underflow, udf5);
            if (q5.size() != 0 && !fresh5) chk("u5 data_out", b5.data_out, q5[0]);
        end
    end

    task automatic cyc8(input logic rs, input logic w, input logic r, input logic [15:0] d);
        @(negedge clk);
        rst = rs; b8.wr_en = w; b8.rd_en = r; b8.data_in = d;
        @(posedge clk);
        #2;
    endtask

    task automatic cyc5(input logic rs, input logic w, input logic r, input logic [15:0] d,
                        output logic [15:0] head);
        @(negedge clk);
        head = b5.data_out;
        rst = rs; b5.wr_en = w; b5.rd_en = r; b5.data_in = d;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] head;
        logic [15:0] recv[$];
        int          sent, cnt;
        logic        w, r;

        b8.wr_en = 0; b8.rd_en = 0; b8.data_in = '0;
        b5.wr_en = 0; b5.rd_en = 0; b5.data_in = '0;

        // Reset state
        cyc8(1, 0, 0, 0);
        cyc8(1, 0, 0, 0);
        chk("rst count", b8.count, 0);
        chk("rst empty", b8.empty, 1);
        chk("rst almostempty", b8.almostempty, 0);
        chk("rst data_out", b8.data_out, 0);

        // Fill 1..8, then a rejected ninth write
        for (int i = 1; i <= 8; i++) begin
            cyc8(0, 1, 0, 16'(i));
            chk("fill wr_ack", b8.wr_ack, 1);
            chk("fill count", b8.count, i);
            chk("fill almostfull", b8.almostfull, (i == 6 || i == 7));
            chk("fill almostempty", b8.almostempty, (i <= 2));
        end
        chk("fill full", b8.full, 1);
        cyc8(0, 1, 0, 16'h0009);
        chk("ovf overflow", b8.overflow, 1);
        chk("ovf wr_ack", b8.wr_ack, 0);
        chk("ovf count", b8.count, 8);

        // Drain in order, then a rejected ninth read
        for (int i = 1; i <= 8; i++) begin
            cyc8(0, 0, 1, 0);
            chk("drain data_out", b8.data_out, i);
        end
        cyc8(0, 0, 1, 0);
        chk("udf underflow", b8.underflow, 1);
        chk("udf data_out hold", b8.data_out, 16'h0008);
        chk("udf empty", b8.empty, 1);
        chk("udf count", b8.count, 0);

        // Simultaneous on full
        for (int i = 1; i <= 8; i++) cyc8(0, 1, 0, 16'(16'h0010 + i));
        cyc8(0, 1, 1, 16'h0099);
        chk("full both count", b8.count, 8);
        chk("full both wr_ack", b8.wr_ack, 1);
        chk("full both data_out", b8.data_out, 16'h0011);

        // Simultaneous on empty
        for (int i = 0; i < 8; i++) cyc8(0, 0, 1, 0);
        chk("drained last", b8.data_out, 16'h0099);
        cyc8(0, 1, 1, 16'h0077);
        chk("empty both underflow", b8.underflow, 1);
        chk("empty both wr_ack", b8.wr_ack, 1);
        chk("empty both count", b8.count, 1);

        // Reset with count=5 and a write pending
        for (int i = 0; i < 4; i++) cyc8(0, 1, 0, 16'(16'h0100 + i));
        chk("pre-reset count", b8.count, 5);
        cyc8(1, 1, 0, 16'h0bad);
        chk("midrst count", b8.count, 0);
        chk("midrst empty", b8.empty, 1);
        chk("midrst wr_ack", b8.wr_ack, 0);
        chk("midrst overflow", b8.overflow, 0);

        // Random traffic on the depth-8 FIFO, biased to reach both ends
        for (int k = 0; k < 600; k++) begin
            w = (k < 300) ? ($urandom_range(3, 0) != 0) : ($urandom_range(3, 0) == 0);
            r = (k < 300) ? ($urandom_range(3, 0) == 0) : ($urandom_range(3, 0) != 0);
            cyc8(($urandom_range(79, 0) == 0), w, r, 16'($urandom));
        end
        cyc8(0, 0, 0, 0);

        // FWFT single word
        cyc5(1, 0, 0, 0, head);
        cyc5(0, 1, 0, 16'hAAAA, head);
        cyc5(0, 0, 0, 0, head);
        chk("fwft data_out", b5.data_out, 16'hAAAA);
        chk("fwft not empty", b5.empty, 0);
        cyc5(0, 0, 1, 0, head);
        chk("fwft popped word", head, 16'hAAAA);
        chk("fwft empty", b5.empty, 1);

        // 20-word stream through depth 5, occupancy held in 1..4
        sent = 0; cnt = 0;
        for (int k = 0; k < 400 && recv.size() < 20; k++) begin
            w = (sent < 20) && (cnt < 4);
            r = ((cnt >= 2) && (cnt == 4 || $urandom_range(1, 0) == 1)) || (sent == 20 && cnt > 0);
            cyc5(0, w, r, 16'(16'h5000 + sent), head);
            if (r) recv.push_back(head);
            if (w) sent++;
            cnt = cnt + int'(w) - int'(r);
        end
        chk("wrap length", recv.size(), 20);
        for (int i = 0; i < 20 && i < recv.size(); i++) chk("wrap word", recv[i], 16'(16'h5000 + i));

        // Random traffic on the FWFT FIFO
        for (int k = 0; k < 600; k++) begin
            w = (k < 300) ? ($urandom_range(3, 0) != 0) : ($urandom_range(3, 0) == 0);
            r = (k < 300) ? ($urandom_range(3, 0) == 0) : ($urandom_range(3, 0) != 0);
            cyc5(($urandom_range(79, 0) == 0), w, r, 16'($urandom), head);
        end
        cyc5(0, 0, 0, 0, head);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
